// File: rtl/fruit_launcher_if.sv
// Signal bundle between the fruit launcher, the game controller and one motion block.
// master = launcher side, slave = controller/motion side.
interface fruit_launcher_if;
    logic       en;
    logic       tick;
    logic       oob;
    logic       sliced;
    logic       obj_rstn;
    logic       obj_moveen;
    logic [9:0] initposx;
    logic [9:0] initposy;
    logic [9:0] initvx;
    logic [9:0] initvy;
    logic       initdx;
    logic       initdy;
    logic [9:0] ax;
    logic [9:0] ay;
    logic [1:0] adx;
    logic [1:0] ady;
    logic       active;
    logic       hit;
    logic       miss;
    logic [7:0] launch_cnt;

    modport master (
        input  en, tick, oob, sliced,
        output obj_rstn, obj_moveen,
        output initposx, initposy, initvx, initvy, initdx, initdy,
        output ax, ay, adx, ady,
        output active, hit, miss, launch_cnt
    );

    modport slave (
        output en, tick, oob, sliced,
        input  obj_rstn, obj_moveen,
        input  initposx, initposy, initvx, initvy, initdx, initdy,
        input  ax, ay, adx, ady,
        input  active, hit, miss, launch_cnt
    );
endinterface

// File: rtl/fruit_launcher.sv
// Launch/retire sequencer for one fruit: picks LFSR launch parameters, arms and
// releases the motion block, then reports hit/miss and cools down before relaunching.
module fruit_launcher #(
    parameter logic [15:0] SEED           = 16'hACE1,
    parameter int unsigned SPAWN_Y        = 440,
    parameter int unsigned CENTER_X       = 320,
    parameter int unsigned AY             = 1,
    parameter int unsigned ARM_CYCLES     = 4,
    parameter int unsigned GRACE_TICKS    = 8,
    parameter int unsigned COOLDOWN_TICKS = 30
) (
    input  logic             clk,
    input  logic             rst,
    fruit_launcher_if.master bus
);
    localparam logic [9:0]  SPAWN_Y_V  = 10'(SPAWN_Y);
    localparam logic [9:0]  CENTER_X_V = 10'(CENTER_X);
    localparam logic [9:0]  AY_V       = 10'(AY);
    localparam logic [15:0] ARM_LAST   = 16'(ARM_CYCLES - 1);
    localparam logic [15:0] GRACE_MAX  = 16'(GRACE_TICKS);
    localparam logic [15:0] CD_LAST    = 16'(COOLDOWN_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_FLY,
        S_RETIRE,
        S_COOLDOWN
    } state_t;

    state_t      state_q;
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic [15:0] arm_cnt_q;
    logic [15:0] grace_q;
    logic [15:0] cd_cnt_q;
    logic        obj_rstn_q;
    logic        obj_moveen_q;
    logic        active_q;
    logic        hit_q;
    logic        miss_q;
    logic [7:0]  launch_cnt_q;
    logic [9:0]  initposx_q;
    logic [9:0]  initposy_q;
    logic [9:0]  initvx_q;
    logic [9:0]  initvy_q;
    logic        initdx_q;
    logic        initdy_q;
    logic [9:0]  ax_q;
    logic [9:0]  ay_q;
    logic [1:0]  adx_q;
    logic [1:0]  ady_q;
    logic [9:0]  posx_d;
    logic        grace_done;

    // Fibonacci LFSR, taps 16,14,13,11; shifts every cycle regardless of state.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        posx_d = 10'd64 + {1'b0, lfsr_q[8:0]};
    end

    assign grace_done = (grace_q == GRACE_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            lfsr_q       <= SEED;
            arm_cnt_q    <= '0;
            grace_q      <= '0;
            cd_cnt_q     <= '0;
            obj_rstn_q   <= 1'b0;
            obj_moveen_q <= 1'b0;
            active_q     <= 1'b0;
            hit_q        <= 1'b0;
            miss_q       <= 1'b0;
            launch_cnt_q <= '0;
            initposx_q   <= '0;
            initposy_q   <= '0;
            initvx_q     <= '0;
            initvy_q     <= '0;
            initdx_q     <= 1'b0;
            initdy_q     <= 1'b0;
            ax_q         <= '0;
            ay_q         <= '0;
            adx_q        <= 2'b00;
            ady_q        <= 2'b00;
        end else begin
            lfsr_q <= lfsr_d;
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.en) begin
                        initposx_q   <= posx_d;
                        initposy_q   <= SPAWN_Y_V;
                        initvx_q     <= {7'd0, lfsr_q[11:9]};
                        initdx_q     <= (posx_d < CENTER_X_V);
                        initvy_q     <= 10'd12 + {7'd0, lfsr_q[15:13]};
                        initdy_q     <= 1'b0;
                        ax_q         <= '0;
                        adx_q        <= 2'b00;
                        ay_q         <= AY_V;
                        ady_q        <= 2'b11;
                        launch_cnt_q <= launch_cnt_q + 8'd1;
                        arm_cnt_q    <= '0;
                        active_q     <= 1'b1;
                        state_q      <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (arm_cnt_q == ARM_LAST) begin
                        obj_rstn_q   <= 1'b1;
                        obj_moveen_q <= 1'b1;
                        grace_q      <= '0;
                        state_q      <= S_FLY;
                    end else begin
                        arm_cnt_q <= arm_cnt_q + 16'd1;
                    end
                end
                S_FLY: begin
                    // A cut always wins over leaving the screen in the same cycle.
                    if (bus.sliced || (bus.oob && grace_done)) begin
                        hit_q        <= bus.sliced;
                        miss_q       <= ~bus.sliced;
                        obj_rstn_q   <= 1'b0;
                        obj_moveen_q <= 1'b0;
                        active_q     <= 1'b0;
                        state_q      <= S_RETIRE;
                    end else if (bus.tick && !grace_done) begin
                        grace_q <= grace_q + 16'd1;
                    end
                end
                S_RETIRE: begin
                    cd_cnt_q <= '0;
                    state_q  <= S_COOLDOWN;
                end
                S_COOLDOWN: begin
                    if (bus.tick) begin
                        if (cd_cnt_q == CD_LAST) begin
                            state_q <= S_IDLE;
                        end else begin
                            cd_cnt_q <= cd_cnt_q + 16'd1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.obj_rstn   = obj_rstn_q;
    assign bus.obj_moveen = obj_moveen_q;
    assign bus.initposx   = initposx_q;
    assign bus.initposy   = initposy_q;
    assign bus.initvx     = initvx_q;
    assign bus.initvy     = initvy_q;
    assign bus.initdx     = initdx_q;
    assign bus.initdy     = initdy_q;
    assign bus.ax         = ax_q;
    assign bus.ay         = ay_q;
    assign bus.adx        = adx_q;
    assign bus.ady        = ady_q;
    assign bus.active     = active_q;
    assign bus.hit        = hit_q;
    assign bus.miss       = miss_q;
    assign bus.launch_cnt = launch_cnt_q;
endmodule
